// File: rtl/system_mm_pkg.sv
// Shared types for the system_mm Avalon-MM initiator.
//   SMM_ADDR_W / SMM_DATA_W / SMM_BE_W : bus widths of the system_mm port
//   smm_init_state_t                   : initiator FSM states
//   smm_cmd_t                          : one captured host command
//   smm_rsp_t                          : one response returned to the host
package system_mm_pkg;

   localparam int SMM_ADDR_W = 13;
   localparam int SMM_DATA_W = 32;
   localparam int SMM_BE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RD,
      ST_RESP
   } smm_init_state_t;

   typedef struct packed {
      logic                  write;
      logic [SMM_ADDR_W-1:0] address;
      logic [SMM_DATA_W-1:0] writedata;
      logic [SMM_BE_W-1:0]   byteenable;
   } smm_cmd_t;

   typedef struct packed {
      logic [SMM_DATA_W-1:0] readdata;
      logic                  error;
   } smm_rsp_t;

endpackage

// File: rtl/system_mm_initiator.sv
// Single-beat Avalon-MM initiator for the system manager's system_mm port.
// Accepts one command at a time on a valid/ready stream, runs it on the bus
// (honouring waitrequest, collecting readdatavalid), and returns one response
// on a valid/ready stream. A cycle timeout recovers from a hung responder.
//   config_clk_clk / config_rst_reset : clock, synchronous active-high reset
//   cmd_*                             : command stream (host -> initiator)
//   rsp_*                             : response stream (initiator -> host)
//   stray_rdv                         : sticky, readdatavalid with no read pending
//   system_mm_*                       : Avalon-MM initiator port
module system_mm_initiator
   import system_mm_pkg::*;
#(
   parameter int unsigned           TIMEOUT_CYCLES = 1024,
   parameter logic [SMM_DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                  config_clk_clk,
   input  logic                  config_rst_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [SMM_ADDR_W-1:0] cmd_address,
   input  logic [SMM_DATA_W-1:0] cmd_writedata,
   input  logic [SMM_BE_W-1:0]   cmd_byteenable,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [SMM_DATA_W-1:0] rsp_readdata,
   output logic                  rsp_error,
   output logic                  stray_rdv,
   input  logic                  system_mm_waitrequest,
   input  logic [SMM_DATA_W-1:0] system_mm_readdata,
   input  logic                  system_mm_readdatavalid,
   output logic [SMM_ADDR_W-1:0] system_mm_address,
   output logic [SMM_DATA_W-1:0] system_mm_writedata,
   output logic [SMM_BE_W-1:0]   system_mm_byteenable,
   output logic                  system_mm_write,
   output logic                  system_mm_read,
   output logic                  system_mm_burstcount,
   output logic                  system_mm_debugaccess
);

   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // The counter holds 0 in the first REQ cycle, so reaching TIMEOUT_CYCLES-1
   // means TIMEOUT_CYCLES bus cycles have elapsed.
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] TO_MAX  = TO_EN ? CNT_W'(TIMEOUT_CYCLES)     : '0;

   smm_init_state_t state_reg, state_next;
   smm_cmd_t        cmd_reg;
   smm_cmd_t        cmd_in;
   smm_rsp_t        rsp_reg;
   logic            rd_reg, wr_reg;
   logic            stray_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic            timeout_hit;
   logic            in_flight;

   assign cmd_in = '{write:      cmd_write,
                     address:    cmd_address,
                     writedata:  cmd_writedata,
                     byteenable: cmd_byteenable};

   assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_WAIT_RD);

   // Next-state logic. In REQ and WAIT_RD the completion term is tested
   // before the timeout so a same-cycle completion wins.
   always_comb begin
      state_next  = state_reg;
      timeout_hit = TO_EN && in_flight && (cnt_reg >= TO_LAST);
      unique case (state_reg)
         ST_IDLE:    if (cmd_valid) state_next = ST_REQ;
         ST_REQ: begin
            if (!system_mm_waitrequest)
               state_next = cmd_reg.write ? ST_RESP : ST_WAIT_RD;
            else if (timeout_hit)
               state_next = ST_RESP;
         end
         ST_WAIT_RD: if (system_mm_readdatavalid || timeout_hit) state_next = ST_RESP;
         ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge config_clk_clk) begin
      if (config_rst_reset) state_reg <= ST_IDLE;
      else                  state_reg <= state_next;
   end

   always_ff @(posedge config_clk_clk) begin
      if (config_rst_reset) begin
         cmd_reg   <= '0;
         rsp_reg   <= '0;
         rd_reg    <= 1'b0;
         wr_reg    <= 1'b0;
         stray_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         // Saturating so a read accepted on the timeout edge still times
         // out one cycle later rather than wrapping.
         if (TO_EN && in_flight && (cnt_reg != TO_MAX))
            cnt_reg <= cnt_reg + CNT_W'(1);

         // Only WAIT_RD expects read data; anything else is dropped and
         // flagged, including late data for a read that already timed out.
         if (system_mm_readdatavalid && (state_reg != ST_WAIT_RD))
            stray_reg <= 1'b1;

         unique case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_reg <= cmd_in;
                  rd_reg  <= !cmd_write;
                  wr_reg  <= cmd_write;
                  cnt_reg <= '0;
               end
            end
            ST_REQ: begin
               if (!system_mm_waitrequest) begin
                  rd_reg <= 1'b0;
                  wr_reg <= 1'b0;
                  if (cmd_reg.write)
                     rsp_reg <= '{readdata: '0, error: 1'b0};
               end else if (timeout_hit) begin
                  rd_reg  <= 1'b0;
                  wr_reg  <= 1'b0;
                  rsp_reg <= '{readdata: (cmd_reg.write ? '0 : ERR_DATA), error: 1'b1};
               end
            end
            ST_WAIT_RD: begin
               if (system_mm_readdatavalid)
                  rsp_reg <= '{readdata: system_mm_readdata, error: 1'b0};
               else if (timeout_hit)
                  rsp_reg <= '{readdata: ERR_DATA, error: 1'b1};
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready             = (state_reg == ST_IDLE);
   assign rsp_valid             = (state_reg == ST_RESP);
   assign rsp_readdata          = rsp_reg.readdata;
   assign rsp_error             = rsp_reg.error;
   assign stray_rdv             = stray_reg;
   assign system_mm_address     = cmd_reg.address;
   assign system_mm_writedata   = cmd_reg.writedata;
   assign system_mm_byteenable  = cmd_reg.byteenable;
   assign system_mm_write       = wr_reg;
   assign system_mm_read        = rd_reg;
   assign system_mm_burstcount  = 1'b1;
   assign system_mm_debugaccess = 1'b0;

endmodule
